// File: rtl/debugger_pkg.sv
// Shared definitions for the USB debugger command path: frame layout,
// sync marker, opcode set and parser states.
package debugger_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned FRAME_LEN     = 9;
  // Frame bytes between SYNC and csum: opcode, addr x2, data x4.
  localparam int unsigned PAYLOAD_LEN   = FRAME_LEN - 2;

  typedef enum logic [7:0] {
    OP_PING   = 8'h01,
    OP_WRITE  = 8'h07,
    OP_READ   = 8'h12,
    OP_STATUS = 8'h33,
    OP_RESET  = 8'h55
  } cmd_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } parser_state_e;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/usb_cmd_parser.sv
// Byte-stream framer for host debugger commands: hunts for SYNC, collects a
// 7-byte payload plus XOR checksum, and presents the command on valid/ready.
module usb_cmd_parser
  import debugger_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd_opcode,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        csum_err,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned     GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      CSUM_IDX = 3'(PAYLOAD_LEN);

  parser_state_e    state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [55:0]      payload_q, payload_d;
  logic [7:0]       xor_q, xor_d;
  logic             csum_ok_q, csum_ok_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [15:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             csum_err_q, csum_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             overrun_err_q, overrun_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Next-state, datapath and error-pulse decode.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    payload_d     = payload_q;
    xor_d         = xor_q;
    csum_ok_d     = csum_ok_q;
    gap_d         = gap_q;
    opcode_d      = opcode_q;
    addr_d        = addr_q;
    data_d        = data_q;
    valid_d       = valid_q;
    csum_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_RECV;
          idx_d   = 3'd0;
          xor_d   = 8'h00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        // A byte always wins over an expiring gap counter.
        if (rx_valid) begin
          gap_d = '0;
          if (idx_q == CSUM_IDX) begin
            csum_ok_d = (rx_data == xor_q);
            state_d   = ST_CHECK;
          end else begin
            payload_d = {payload_q[47:0], rx_data};
            xor_d     = csum_step(xor_q, rx_data);
            idx_d     = idx_q + 3'd1;
          end
        end else if (gap_q == GAP_LAST) begin
          timeout_err_d = 1'b1;
          gap_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_CHECK: begin
        overrun_err_d = rx_valid;
        if (csum_ok_q) begin
          opcode_d = payload_q[55:48];
          addr_d   = payload_q[47:32];
          data_d   = payload_q[31:0];
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          csum_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        overrun_err_d = rx_valid;
        if (cmd_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((csum_err_d || timeout_err_d || overrun_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= 3'd0;
      payload_q     <= 56'd0;
      xor_q         <= 8'h00;
      csum_ok_q     <= 1'b0;
      gap_q         <= '0;
      opcode_q      <= 8'h00;
      addr_q        <= 16'h0000;
      data_q        <= 32'h0000_0000;
      valid_q       <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      err_cnt_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      payload_q     <= payload_d;
      xor_q         <= xor_d;
      csum_ok_q     <= csum_ok_d;
      gap_q         <= gap_d;
      opcode_q      <= opcode_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      csum_err_q    <= csum_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign cmd_opcode  = opcode_q;
  assign cmd_addr    = addr_q;
  assign cmd_data    = data_q;
  assign cmd_valid   = valid_q;
  assign csum_err    = csum_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Scoreboard bench for usb_cmd_parser: stimulus pushes expected commands,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_usb_cmd_parser;

  localparam int         TIMEOUT = 50000;
  localparam logic [7:0] SYNC    = 8'hA5;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        csum_err;
  logic        timeout_err;
  logic        overrun_err;
  logic [7:0]  err_cnt;

  always #5 sys_clk = ~sys_clk;

  usb_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(TIMEOUT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_opcode (cmd_opcode),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .csum_err   (csum_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .err_cnt    (err_cnt)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Written only by the stimulus process.
  cmd_t cmd_q[$];
  int   lat_q[$];
  int   exp_csum = 0, exp_to = 0, exp_ovr = 0, exp_errcnt = 0;
  int   to_ref = -1;
  int   drv_cyc = 0;
  int   chk_seq = 0, chk_kind = 0;
  bit   rand_ready = 1'b0;
  bit   done = 1'b0;

  // Written only by the monitor process.
  int   n_checks = 0, n_fail = 0;
  int   cnt_csum = 0, cnt_to = 0, cnt_ovr = 0;
  int   seen_seq = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  cmd_t prev_cmd = '0;
  cmd_t exp_c;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    drv_cyc  = cyc;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic bump(input int n);
    exp_errcnt = (exp_errcnt + n > 255) ? 255 : exp_errcnt + n;
  endtask

  task automatic checkpoint(input int kind);
    chk_kind = kind;
    chk_seq++;
    tick();
  endtask

  task automatic wait_consumed();
    for (int n = 0; n < 300 && cmd_q.size() != 0; n++) tick();
    tick();
  endtask

  // Reference model: csum is the XOR of the seven payload bytes; a nonzero
  // mask corrupts it so the frame must be rejected.
  task automatic send_frame(input logic [7:0] op, input logic [15:0] addr,
                            input logic [31:0] data, input logic [7:0] mask,
                            input int max_gap);
    logic [7:0] fb [7];
    logic [7:0] x;
    cmd_t       c;
    fb[0] = op;           fb[1] = addr[15:8];   fb[2] = addr[7:0];
    fb[3] = data[31:24];  fb[4] = data[23:16];  fb[5] = data[15:8];
    fb[6] = data[7:0];
    x = 8'h00;
    send_byte(SYNC);
    for (int i = 0; i < 7; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      send_byte(fb[i]);
      x = x ^ fb[i];
    end
    repeat ($urandom_range(0, max_gap)) tick();
    send_byte(x ^ mask);
    if (mask == 8'h00) begin
      c.op = op; c.addr = addr; c.data = data;
      cmd_q.push_back(c);
      lat_q.push_back(drv_cyc);
    end else begin
      exp_csum++;
      bump(1);
    end
  endtask

  // Monitor: pulse counting, latency, hold stability, command scoreboard, checkpoints.
  always @(negedge sys_clk) begin
    if (csum_err)    cnt_csum++;
    if (overrun_err) cnt_ovr++;
    if (timeout_err) begin
      cnt_to++;
      if (to_ref >= 0) check("timeout_latency", 64'(cyc - to_ref), 64'(TIMEOUT + 1));
    end
    if (cmd_valid && !prev_valid) begin
      if (lat_q.size() == 0) check("cmd_valid_unexpected", 64'(cmd_valid), 64'd0);
      else check("cmd_latency", 64'(cyc), 64'(lat_q.pop_front() + 2));
    end
    if (prev_valid && !prev_ready)
      check("hold_stable", {cmd_valid, cmd_opcode, cmd_addr, cmd_data}, {1'b1, prev_cmd});
    if (cmd_valid && cmd_ready) begin
      if (cmd_q.size() == 0) check("cmd_unexpected", 64'(cmd_valid), 64'd0);
      else begin
        exp_c = cmd_q.pop_front();
        check("cmd_opcode", 64'(cmd_opcode), 64'(exp_c.op));
        check("cmd_addr",   64'(cmd_addr),   64'(exp_c.addr));
        check("cmd_data",   64'(cmd_data),   64'(exp_c.data));
      end
    end
    if (chk_seq != seen_seq) begin
      seen_seq = chk_seq;
      if (chk_kind == 0) begin
        check("rst_cmd_valid",   64'(cmd_valid),   64'd0);
        check("rst_cmd_opcode",  64'(cmd_opcode),  64'd0);
        check("rst_cmd_addr",    64'(cmd_addr),    64'd0);
        check("rst_cmd_data",    64'(cmd_data),    64'd0);
        check("rst_csum_err",    64'(csum_err),    64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_overrun_err", 64'(overrun_err), 64'd0);
        check("rst_err_cnt",     64'(err_cnt),     64'd0);
      end else begin
        check("csum_err_count",    64'(cnt_csum),     64'(exp_csum));
        check("timeout_err_count", 64'(cnt_to),       64'(exp_to));
        check("overrun_err_count", 64'(cnt_ovr),      64'(exp_ovr));
        check("err_cnt",           64'(err_cnt),      64'(exp_errcnt));
        check("pending_cmds",      64'(cmd_q.size()), 64'd0);
        check("idle_cmd_valid",    64'(cmd_valid),    64'd0);
      end
    end
    prev_valid = cmd_valid;
    prev_ready = cmd_ready;
    prev_cmd   = {cmd_opcode, cmd_addr, cmd_data};
    if (done) begin
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] mask;
    int         ng;
    sys_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    checkpoint(0);

    // A5 12 00 00 00 00 00 01 13
    send_frame(8'h12, 16'h0000, 32'h0000_0001, 8'h00, 0);
    wait_consumed();
    checkpoint(1);

    // Leading garbage, then A5 07 00 00 00 64 00 32 51
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h07, 16'h0000, 32'h0064_0032, 8'h00, 0);
    wait_consumed();
    checkpoint(1);

    // Same first frame with csum 14 instead of 13
    send_frame(8'h12, 16'h0000, 32'h0000_0001, 8'h07, 0);
    tick(); tick();
    checkpoint(1);

    // Byte dropped during CHECK of a bad frame: two pulses, one err_cnt step
    send_frame(8'h33, 16'h4000, 32'h1357_9BDF, 8'h80, 1);
    send_byte(8'h33);
    exp_ovr++;
    tick(); tick();
    checkpoint(1);

    // Inter-byte timeout after A5 12, then recovery
    send_byte(SYNC);
    send_byte(8'h12);
    to_ref = drv_cyc;
    exp_to++;
    bump(1);
    repeat (TIMEOUT + 5) tick();
    to_ref = -1;
    send_frame(8'h55, 16'hBEEF, 32'hDEAD_BEEF, 8'h00, 0);
    wait_consumed();
    checkpoint(1);

    // Overrun while holding: bytes dropped, SYNC in HOLD starts nothing
    cmd_ready = 1'b0;
    send_frame(8'h01, 16'h1234, 32'hCAFE_F00D, 8'h00, 0);
    repeat (3) tick();
    send_byte(SYNC);
    tick();
    send_byte(8'h12);
    send_byte(8'h34);
    exp_ovr += 3;
    bump(3);
    repeat (4) tick();
    cmd_ready = 1'b1;
    wait_consumed();
    checkpoint(1);
    send_frame(8'h07, 16'h00A0, 32'h1122_3344, 8'h00, 0);
    wait_consumed();
    checkpoint(1);

    // Reset mid-frame drops it silently
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    exp_errcnt = 0;
    tick();
    checkpoint(0);
    send_frame(8'h12, 16'h8001, 32'h0BAD_CAFE, 8'h00, 0);
    wait_consumed();
    checkpoint(1);

    // Randomized frames, payloads may contain SYNC, random back-pressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      ng = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h5A;
        send_byte(b);
      end
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(8'($urandom), 16'($urandom), $urandom, mask, 2);
      if (mask == 8'h00) wait_consumed();
      else begin tick(); tick(); end
    end
    rand_ready = 1'b0;
    cmd_ready  = 1'b1;
    tick();
    checkpoint(1);

    // err_cnt saturation through a long overrun burst
    cmd_ready = 1'b0;
    send_frame(8'h12, 16'h0001, 32'h0000_0002, 8'h00, 0);
    repeat (3) tick();
    for (int i = 0; i < 260; i++) send_byte(8'($urandom));
    exp_ovr += 260;
    bump(260);
    tick();
    cmd_ready = 1'b1;
    wait_consumed();
    checkpoint(1);

    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    exp_errcnt = 0;
    tick();
    checkpoint(0);
    checkpoint(1);
    done = 1'b1;
    repeat (5) tick();
  end

endmodule

// File: doc/usb_cmd_parser.md
USB_CMD_PARSER -- requirements
Module: usb_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, the maximum inter-byte gap in sys_clk cycles (1 ms at 50 MHz).
REQ-003 SHALL have port sys_clk  in  1  the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  in  8  the received USB-UART byte.
REQ-006 SHALL have port rx_valid  in  1  a one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port cmd_opcode  out  8  the decoded opcode.
REQ-008 SHALL have port cmd_addr  out  16  the decoded address.
REQ-009 SHALL have port cmd_data  out  32  the decoded data word.
REQ-010 SHALL have port cmd_valid  out  1  command available (valid/ready handshake).
REQ-011 SHALL have port cmd_ready  in  1  the downstream register file accepts the command.
REQ-012 SHALL have port csum_err  out  1  one-cycle pulse on checksum mismatch.
REQ-013 SHALL have port timeout_err  out  1  one-cycle pulse on inter-byte timeout.
REQ-014 SHALL have port overrun_err  out  1  one-cycle pulse when a byte is dropped while cmd_valid is high.
REQ-015 SHALL have port err_cnt  out  8  saturating count of all error pulses.

Function
REQ-016 SHALL use the frame format SYNC, opcode, addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0], csum (9 bytes).
REQ-017 SHALL compute csum as the XOR of the 7 bytes from opcode through data[7:0]; SYNC is excluded.
REQ-018 SHALL implement the states IDLE, RECV, CHECK, HOLD.
REQ-019 In IDLE, SHALL discard bytes until rx_valid is high with rx_data==SYNC_BYTE, then go to RECV with byte index 0 and running XOR 0.
REQ-020 In RECV, SHALL shift each byte into a 56-bit payload register and update the XOR; after index 6 the next byte is the csum, and receiving it moves the state to CHECK.
REQ-021 A byte equal to SYNC_BYTE inside RECV SHALL be treated as payload; there is no resynchronisation mid-frame.
REQ-022 In CHECK (one cycle), on a match SHALL load the cmd_* outputs and go to HOLD with cmd_valid=1; on a mismatch SHALL pulse csum_err and go to IDLE.
REQ-023 Latency: cmd_valid SHALL assert exactly 2 cycles after the cycle in which the csum byte's rx_valid is sampled.
REQ-024 In HOLD, SHALL keep cmd_valid and cmd_* stable until cmd_valid&&cmd_ready; cmd_valid SHALL then deassert in the next cycle and the state SHALL return to IDLE.
REQ-025 Any rx_valid seen in CHECK or HOLD SHALL be dropped and SHALL pulse overrun_err; a SYNC byte dropped in HOLD SHALL NOT start a frame.
REQ-026 The gap counter SHALL reset on every accepted byte in RECV and increment otherwise; on reaching TIMEOUT_CYC it SHALL pulse timeout_err, discard the partial frame, and go to IDLE.
REQ-027 A timeout and a byte arriving in the same cycle SHALL give priority to the byte; no timeout is raised.
REQ-028 err_cnt SHALL increment by 1 per cycle in which any error pulse is high (simultaneous pulses count once) and SHALL saturate at 8'hFF.

Reset
REQ-029 While sys_rst is high, SHALL set state=IDLE, cmd_valid=0, cmd_opcode=0, cmd_addr=0, cmd_data=0, all error pulses=0, err_cnt=0, index=0, XOR=0, and gap counter=0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL drop the frame or pending command without any error pulse.

Structure
REQ-031 SYNC_BYTE default, the frame length (9), and the opcode constants (8'h01..8'h55) SHALL live in the shared package debugger_pkg.
REQ-032 SHALL be one flat module; no sub-module.

Verification
REQ-033 Bytes A5 12 00 00 00 00 00 01 13 -> cmd_valid with opcode 0x12, addr 0x0000, data 0x00000001; err_cnt stays 0.
REQ-034 Bytes 00 FF A5 07 00 00 00 64 00 32 51 -> leading garbage ignored; cmd opcode 0x07, addr 0x0000, data 0x00640032.
REQ-035 The REQ-033 frame with csum 14 -> csum_err pulse, no cmd_valid, err_cnt=1.
REQ-036 A5 12 then idle for 50000 cycles -> timeout_err pulse, state IDLE; a following valid frame decodes correctly.
REQ-037 cmd_ready held low after a good frame, then 3 bytes sent -> 3 overrun_err pulses and cmd_* stable; cmd_ready=1 -> one handshake, then cmd_valid=0.
REQ-038 sys_rst pulsed after byte 4 of a frame, then a full good frame sent -> only the second frame produces cmd_valid, with no error pulses.
